// File: rtl/bcd_seg_scan.sv
// -----------------------------------------------------------------------------
// bcd_seg_scan
// Display stage for a two-digit BCD countdown (24..00 shot timer). It scans a
// common-anode 2-digit 7-segment display, blinks the whole display after each
// expiry/reload event, and can blank a leading zero on the tens digit.
//
// Ports
//   clk    in   1  system clock, all state on the rising edge
//   reset  in   1  asynchronous, active-low reset
//   bcd    in   8  packed count: [7:4] tens, [3:0] units
//   carry  in   1  reload flag (level); its rising edge is the expiry event
//   an     out  2  active-low digit enables: an[0] units, an[1] tens
//   seg    out  8  active-low segments: [7]=dp (always off), [6:0]=g..a
//   blink  out  1  high while a blink sequence is in progress
//
// All outputs are registered. an/seg follow the slot select and the frame
// snapshot with a fixed one-cycle latency, so they always change together.
// -----------------------------------------------------------------------------
module bcd_seg_scan #(
    parameter logic [15:0] SCAN_DIV    = 16'd50000, // clk cycles per digit slot, 2..65535
    parameter logic [7:0]  BLINK_TICKS = 8'd100,    // slot ticks per blink half-period, 1..255
    parameter logic [3:0]  BLINK_N     = 4'd3,      // off/on pairs per event, 0 disables
    parameter logic        LZB         = 1'b1       // 1 = blank tens digit when it is 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bcd,
    input  logic       carry,
    output logic [1:0] an,
    output logic [7:0] seg,
    output logic       blink
);

    localparam logic [15:0] DIV_MAX   = SCAN_DIV - 16'd1;
    localparam logic [7:0]  PHASE_MAX = BLINK_TICKS - 8'd1;
    localparam logic [4:0]  REM_LOAD  = {BLINK_N, 1'b0};   // two half-periods per pair

    // scan state
    logic [15:0] div_cnt;
    logic        sel;
    logic [7:0]  disp;

    // blink state
    logic        carry_q;
    logic        live;       // low only until the first clock after reset
    logic [4:0]  rem;
    logic [7:0]  phase_cnt;
    logic        off;

    logic        tick;
    logic        event_hit;

    assign tick      = (div_cnt == DIV_MAX);
    // live keeps a carry that is already high at reset release from
    // looking like a fresh edge: carry_q gets to sample it first.
    assign event_hit = carry & ~carry_q & live;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;   // non-BCD nibble shows a dash
        endcase
        return s;
    endfunction

    // Slot divider, digit select and once-per-frame snapshot. The snapshot
    // is taken when the tens slot ends, so a frame never mixes two counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= 16'd0;
            sel     <= 1'b0;
            disp    <= 8'h00;
        end else begin
            if (tick) begin
                div_cnt <= 16'd0;
                sel     <= ~sel;
                if (sel) begin
                    disp <= bcd;
                end
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

    // Blink sequencer. An event always (re)starts the sequence and takes
    // priority over a tick in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_q   <= 1'b0;
            live      <= 1'b0;
            rem       <= 5'd0;
            phase_cnt <= 8'd0;
            off       <= 1'b0;
            blink     <= 1'b0;
        end else begin
            carry_q <= carry;
            live    <= 1'b1;
            if (event_hit && (BLINK_N != 4'd0)) begin
                rem       <= REM_LOAD;
                phase_cnt <= 8'd0;
                off       <= 1'b1;
                blink     <= 1'b1;
            end else if (blink && tick) begin
                if (phase_cnt == PHASE_MAX) begin
                    phase_cnt <= 8'd0;
                    rem       <= rem - 5'd1;
                    if (rem == 5'd1) begin
                        off   <= 1'b0;
                        blink <= 1'b0;
                    end else begin
                        off   <= ~off;
                    end
                end else begin
                    phase_cnt <= phase_cnt + 8'd1;
                end
            end
        end
    end

    // Next values for the output registers, from current sel/disp/off.
    logic [1:0] an_nxt;
    logic [7:0] seg_nxt;
    logic [3:0] digit;

    always_comb begin
        digit   = sel ? disp[7:4] : disp[3:0];
        an_nxt  = sel ? 2'b01 : 2'b10;
        if (sel && LZB && (disp[7:4] == 4'd0)) begin
            an_nxt = 2'b11;
        end
        if (off) begin
            an_nxt = 2'b11;
        end
        seg_nxt = {1'b1, decode(digit)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 2'b11;
            seg <= 8'hFF;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_seg_scan
// Two instances share all inputs: dut (LZB=1) and dut_nlzb (LZB=0). A
// cycle model written in terms of slot ticks elapsed since the last event
// pushes the expected {blink, an, seg, an_nlzb} after every rising edge;
// the negedge checker pops and compares.
// -----------------------------------------------------------------------------
module tb_bcd_seg_scan;

    localparam int SD = 4;
    localparam int BT = 2;
    localparam int BN = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] bcd = 8'h24;
    logic       carry = 1'b0;
    logic [1:0] an, an_nlzb;
    logic [7:0] seg, seg_nlzb;
    logic       blink, blink_nlzb;

    int n_tests = 0;
    int n_fail  = 0;
    int blink_rises = 0;
    logic blink_prev = 1'b0;

    logic [12:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    bcd_seg_scan #(.SCAN_DIV(16'd4), .BLINK_TICKS(8'd2), .BLINK_N(4'd2), .LZB(1'b1)) dut (
        .clk(clk), .reset(reset), .bcd(bcd), .carry(carry),
        .an(an), .seg(seg), .blink(blink)
    );

    bcd_seg_scan #(.SCAN_DIV(16'd4), .BLINK_TICKS(8'd2), .BLINK_N(4'd2), .LZB(1'b0)) dut_nlzb (
        .clk(clk), .reset(reset), .bcd(bcd), .carry(carry),
        .an(an_nlzb), .seg(seg_nlzb), .blink(blink_nlzb)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'h40; 4'd1: s = 7'h79; 4'd2: s = 7'h24; 4'd3: s = 7'h30;
            4'd4: s = 7'h19; 4'd5: s = 7'h12; 4'd6: s = 7'h02; 4'd7: s = 7'h78;
            4'd8: s = 7'h00; 4'd9: s = 7'h10;
            default: s = 7'h3F;
        endcase
        return {1'b1, s};
    endfunction

    // ---------------- reference model ----------------
    int         m_div = 0;
    logic       m_sel = 1'b0;
    logic [7:0] m_disp = 8'h00;
    logic       m_cq = 1'b0;
    logic       m_live = 1'b0;
    logic       m_active = 1'b0;
    int         m_et = 0;        // slot ticks since the last event

    task automatic model_reset();
        m_div = 0; m_sel = 1'b0; m_disp = 8'h00; m_cq = 1'b0;
        m_live = 1'b0; m_active = 1'b0; m_et = 0;
    endtask

    always @(negedge reset) model_reset();

    always @(posedge clk) begin
        logic       m_off, m_tick, m_ev;
        logic [1:0] e_an, e_an2;
        logic [7:0] e_seg;
        logic [3:0] dig;
        if (!reset) begin
            model_reset();
            exp_q.push_back({1'b0, 2'b11, 8'hFF, 2'b11});
        end else begin
            // outputs come from the state held before this edge
            m_off = m_active && (((m_et / BT) % 2) == 0);
            dig   = m_sel ? m_disp[7:4] : m_disp[3:0];
            e_seg = seg_of(dig);
            e_an2 = m_sel ? 2'b01 : 2'b10;
            e_an  = (m_sel && m_disp[7:4] == 4'd0) ? 2'b11 : e_an2;
            if (m_off) begin
                e_an  = 2'b11;
                e_an2 = 2'b11;
            end
            m_tick = (m_div == SD - 1);
            m_ev   = carry && !m_cq && m_live;
            if (m_ev && BN > 0) begin
                m_active = 1'b1;
                m_et     = 0;
            end else if (m_active && m_tick) begin
                m_et++;
                if (m_et == 2 * BN * BT) m_active = 1'b0;
            end
            if (m_tick) begin
                if (m_sel) m_disp = bcd;
                m_sel = !m_sel;
                m_div = 0;
            end else begin
                m_div++;
            end
            m_cq   = carry;
            m_live = 1'b1;
            exp_q.push_back({m_active, e_an, e_seg, e_an2});
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [12:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("blink",    {31'd0, blink},  {31'd0, e[12]});
            check("an",       {30'd0, an},     {30'd0, e[11:10]});
            check("seg",      {24'd0, seg},    {24'd0, e[9:2]});
            check("an_nlzb",  {30'd0, an_nlzb},  {30'd0, e[1:0]});
            check("seg_nlzb", {24'd0, seg_nlzb}, {24'd0, e[9:2]});
        end
        if (blink && !blink_prev) blink_rises++;
        blink_prev = blink;
    end

    // ---------------- driver ----------------
    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        // reset state
        run(3);
        check("rst_an",    {30'd0, an},   32'h3);
        check("rst_seg",   {24'd0, seg},  32'hFF);
        check("rst_blink", {31'd0, blink}, 32'h0);
        reset = 1'b1;

        // scan patterns
        run(40);
        bcd = 8'h07; run(40);
        bcd = 8'h3C; run(40);
        for (int i = 0; i < 4; i++) begin
            bcd = {$urandom_range(0, 9) & 4'hF, $urandom_range(0, 9) & 4'hF};
            run(24);
        end
        bcd = 8'h24;

        // single event, carry held high through and beyond the sequence
        blink_rises = 0;
        carry = 1'b1; run(60);
        check("one_seq", blink_rises, 1);
        carry = 1'b0; run(4);

        // second edge mid-sequence restarts it without a gap
        blink_rises = 0;
        carry = 1'b1; run(14);
        carry = 1'b0; run(2);
        carry = 1'b1; run(50);
        check("restart_seq", blink_rises, 1);
        carry = 1'b0; run(4);

        // reset during the off-phase, carry still high at release
        carry = 1'b1; run(3);
        check("off_phase_an", {30'd0, an}, 32'h3);
        check("in_blink",     {31'd0, blink}, 32'h1);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        check("async_an",    {30'd0, an},    32'h3);
        check("async_seg",   {24'd0, seg},   32'hFF);
        check("async_blink", {31'd0, blink}, 32'h0);
        run(3);
        blink_rises = 0;
        reset = 1'b1;
        run(60);
        check("no_evt_after_rst", blink_rises, 0);
        carry = 1'b0; run(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
